sprite_anim_ctrl: RTL

Generates the direction code (`start`) and animation step (`step`) consumed by the sprite frame-index multiplexer, plus the sprite's on-screen position. It sits between the debounced direction buttons and the sprite renderer, and advances once per VGA frame on `frame_tick`. It holds walk-cycle timing, facing direction and saturating position, so the downstream multiplexer and ROM stay purely combinational.

---
 rtl/sprite_anim_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: tracks facing direction, walk-cycle step and
// saturating on-screen position, advancing once per frame_tick.
module sprite_anim_ctrl #(
    parameter int TICKS_PER_STEP = 8,
    parameter int SPEED          = 2,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 32,
    parameter int X_INIT         = 100,
    parameter int Y_INIT         = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] start,
    output logic [1:0] step,
    output logic       moving,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    typedef enum logic {
        IDLE,
        WALK
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int          CW        = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_STEP - 1);
    localparam logic [10:0] SPEED_W   = 11'(SPEED);
    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - SPRITE_H);
    localparam logic [9:0]  X_RST     = 10'(X_INIT);
    localparam logic [9:0]  Y_RST     = 10'(Y_INIT);

    state_t         state_q, state_d;
    dir_t           start_q, start_d;
    logic [1:0]     step_q, step_d;
    logic [CW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           moving_q, moving_d;
    logic [9:0]     pos_x_q, pos_x_d;
    logic [9:0]     pos_y_q, pos_y_d;

    logic           req;
    dir_t           req_dir;
    logic [10:0]    px_ext, py_ext, px_sum, py_sum;
    logic [9:0]     px_mv, py_mv;

    // Requested direction with fixed priority up > down > left > right
    always_comb begin
        req     = btn_up | btn_down | btn_left | btn_right;
        req_dir = DIR_RIGHT;
        if (btn_up) begin
            req_dir = DIR_UP;
        end else if (btn_down) begin
            req_dir = DIR_DOWN;
        end else if (btn_left) begin
            req_dir = DIR_LEFT;
        end
    end

    // Candidate position after one saturating move in the requested direction
    always_comb begin
        px_ext = {1'b0, pos_x_q};
        py_ext = {1'b0, pos_y_q};
        px_sum = px_ext + SPEED_W;
        py_sum = py_ext + SPEED_W;
        px_mv  = pos_x_q;
        py_mv  = pos_y_q;
        case (req_dir)
            DIR_UP:    py_mv = (py_ext < SPEED_W) ? '0 : 10'(py_ext - SPEED_W);
            DIR_DOWN:  py_mv = (py_sum > Y_MAX) ? Y_MAX[9:0] : py_sum[9:0];
            DIR_LEFT:  px_mv = (px_ext < SPEED_W) ? '0 : 10'(px_ext - SPEED_W);
            DIR_RIGHT: px_mv = (px_sum > X_MAX) ? X_MAX[9:0] : px_sum[9:0];
            default:   ;
        endcase
    end

    // Next-state decision, only evaluated on an enabled frame tick
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        step_d     = step_q;
        tick_cnt_d = tick_cnt_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        if (enable && frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d    = WALK;
                        start_d    = req_dir;
                        step_d     = '0;
                        tick_cnt_d = '0;
                        pos_x_d    = px_mv;
                        pos_y_d    = py_mv;
                    end
                end
                WALK: begin
                    if (!req) begin
                        state_d    = IDLE;
                        step_d     = '0;
                        tick_cnt_d = '0;
                    end else if (req_dir != start_q) begin
                        start_d    = req_dir;
                        step_d     = '0;
                        tick_cnt_d = '0;
                        pos_x_d    = px_mv;
                        pos_y_d    = py_mv;
                    end else begin
                        pos_x_d = px_mv;
                        pos_y_d = py_mv;
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_d = '0;
                            step_d     = step_q + 2'd1;
                        end else begin
                            tick_cnt_d = tick_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        moving_d = (state_d == WALK);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            start_q    <= DIR_DOWN;
            step_q     <= '0;
            tick_cnt_q <= '0;
            moving_q   <= 1'b0;
            pos_x_q    <= X_RST;
            pos_y_q    <= Y_RST;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            moving_q   <= moving_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
        end
    end

    assign start  = start_q;
    assign step   = step_q;
    assign moving = moving_q;
    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;

endmodule
